instruction_fetch_unit: RTL and testbench

//  RV32IM IF stage: owns the PC, fetches from instruction memory through a busywait handshake, and

---
 rtl/rv32im_pkg.sv | 19 +
 rtl/instruction_fetch_unit_if.sv | 13 +
 rtl/instruction_fetch_unit_pc_register.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: datapath width, canonical NOP, and fetch-stage encodings.
package rv32im_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } if_state_t;

   typedef enum logic [1:0] {
      PC_SEL_INC      = 2'd0,
      PC_SEL_TARGET   = 2'd1,
      PC_SEL_REDIRECT = 2'd2
   } pc_sel_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory busywait bus between the fetch unit (master) and imem (slave).
interface instruction_fetch_unit_if;
   import rv32im_pkg::*;

   logic            IMEM_READ;
   logic [XLEN-1:0] IMEM_ADDRESS;
   logic [XLEN-1:0] IMEM_READDATA;
   logic            IMEM_BUSYWAIT;

   modport master (output IMEM_READ, IMEM_ADDRESS, input IMEM_READDATA, IMEM_BUSYWAIT);
   modport slave  (input IMEM_READ, IMEM_ADDRESS, output IMEM_READDATA, IMEM_BUSYWAIT);

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop plus next-PC mux; only advances when the fetch FSM enables it.
module if_pc_register
   import rv32im_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            en,
   input  pc_sel_t         sel,
   input  logic [XLEN-1:0] target,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_q
);

   logic [XLEN-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (en) begin
         case (sel)
            PC_SEL_INC:      pc_d = pc_q + XLEN'(4);
            PC_SEL_TARGET:   pc_d = target;
            PC_SEL_REDIRECT: pc_d = redirect_pc;
            default:         pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM IF stage: PC ownership, busywait fetch, 1-entry stall hold buffer, in-flight redirect.
module instruction_fetch_unit
   import rv32im_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = rv32im_pkg::NOP_INSTR
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     STALL,
   input  logic                     BRANCH_TAKEN,
   input  logic [XLEN-1:0]          BRANCH_TARGET,
   instruction_fetch_unit_if.master imem,
   output logic [XLEN-1:0]          INSTRUCTION,
   output logic [XLEN-1:0]          PC,
   output logic [XLEN-1:0]          PC_PLUS_4,
   output logic                     VALID
);

   if_state_t       state_q, state_d;
   logic [XLEN-1:0] hold_buf_q, hold_buf_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] target;
   logic            pc_en;
   pc_sel_t         pc_sel;
   logic            busy;

   assign busy   = imem.IMEM_BUSYWAIT;
   assign target = BRANCH_TARGET & ~XLEN'(3);

   if_pc_register #(.RESET_PC(RESET_PC)) u_pc (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .en          (pc_en),
      .sel         (pc_sel),
      .target      (target),
      .redirect_pc (redirect_pc_q),
      .pc_q        (pc_q)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= S_REQ;
         hold_buf_q    <= NOP_INSTR;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_buf_q    <= hold_buf_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hold_buf_d    = hold_buf_q;
      redirect_pc_d = redirect_pc_q;
      pc_en         = 1'b0;
      pc_sel        = PC_SEL_INC;
      // An outstanding access cannot be aborted, so redirects wait in redirect_pc until it drains.
      if (BRANCH_TAKEN) begin
         if (busy && (state_q == S_REQ || state_q == S_DISCARD)) begin
            redirect_pc_d = target;
            state_d       = S_DISCARD;
         end else begin
            pc_en   = 1'b1;
            pc_sel  = PC_SEL_TARGET;
            state_d = S_REQ;
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (!busy) begin
                  if (!STALL) begin
                     pc_en = 1'b1;
                  end else begin
                     hold_buf_d = imem.IMEM_READDATA;
                     state_d    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!STALL) begin
                  pc_en   = 1'b1;
                  state_d = S_REQ;
               end
            end
            S_DISCARD: begin
               if (!busy) begin
                  pc_en   = 1'b1;
                  pc_sel  = PC_SEL_REDIRECT;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   assign imem.IMEM_ADDRESS = pc_q;
   assign imem.IMEM_READ    = RESET_N && (state_q != S_HOLD);

   // No output flop here: ID_IF_register captures these directly.
   always_comb begin
      INSTRUCTION = NOP_INSTR;
      VALID       = 1'b0;
      PC          = pc_q;
      PC_PLUS_4   = pc_q + XLEN'(4);
      if (RESET_N && !BRANCH_TAKEN) begin
         case (state_q)
            S_REQ: begin
               if (!busy) begin
                  INSTRUCTION = imem.IMEM_READDATA;
                  VALID       = 1'b1;
               end
            end
            S_HOLD: begin
               INSTRUCTION = hold_buf_q;
               VALID       = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: driver pushes expected fetches into a queue, negedge monitor pops on VALID.
module tb_instruction_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        CLK;
   logic        RESET_N;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC;
   logic [31:0] PC_PLUS_4;
   logic        VALID;

   logic        busy;
   logic        ovr_en;
   logic [31:0] ovr_data;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   instruction_fetch_unit_if imem ();

   instruction_fetch_unit dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .imem          (imem),
      .INSTRUCTION   (INSTRUCTION),
      .PC            (PC),
      .PC_PLUS_4     (PC_PLUS_4),
      .VALID         (VALID)
   );

   // Zero-latency memory: word = address ^ A5A5_0000 unless overridden.
   assign imem.IMEM_BUSYWAIT = busy;
   assign imem.IMEM_READDATA = ovr_en ? ovr_data : (imem.IMEM_ADDRESS ^ 32'hA5A5_0000);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] tgt, input logic bw);
      @(posedge CLK); #1;
      STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; busy = bw;
   endtask

   task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] instr);
      exp_q.push_back(exp_t'{pc: pc, instr: instr});
   endtask

   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && VALID === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual pc=%08h required=no valid output", PC);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_instr", INSTRUCTION, mon_e.instr);
            chk("sb_pc", PC, mon_e.pc);
            chk("sb_pc_plus_4", PC_PLUS_4, mon_e.pc + 32'd4);
         end
      end
   end

   initial begin
      RESET_N = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
      busy = 1'b0; ovr_en = 1'b0; ovr_data = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_read", {31'd0, imem.IMEM_READ}, 32'd0);
      chk("rst_valid", {31'd0, VALID}, 32'd0);
      chk("rst_instr", INSTRUCTION, 32'h0000_0013);
      chk("rst_pc", PC, 32'h0);
      chk("rst_pc_plus_4", PC_PLUS_4, 32'h4);

      // T1: sequential zero-wait fetch
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      expect_fetch(32'h0, memw(32'h0));
      drive(0, 0, 0, 0); expect_fetch(32'h4, memw(32'h4));

      // T2: busywait at PC=8
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1);
         @(negedge CLK);
         chk("bw_addr", imem.IMEM_ADDRESS, 32'h8);
         chk("bw_valid", {31'd0, VALID}, 32'd0);
      end
      drive(0, 0, 0, 0); expect_fetch(32'h8, memw(32'h8));
      drive(0, 0, 0, 0); expect_fetch(32'hC, memw(32'hC));

      // T3: stall holds word from PC=10
      drive(1, 0, 0, 0); ovr_en = 1'b1; ovr_data = 32'h1234_5678;
      expect_fetch(32'h10, 32'h1234_5678);
      drive(1, 0, 0, 0); ovr_en = 1'b0;
      expect_fetch(32'h10, 32'h1234_5678);
      @(negedge CLK);
      chk("stall_read", {31'd0, imem.IMEM_READ}, 32'd0);
      drive(0, 0, 0, 0); expect_fetch(32'h10, 32'h1234_5678);
      drive(0, 0, 0, 0); expect_fetch(32'h14, memw(32'h14));
      drive(0, 0, 0, 0); expect_fetch(32'h18, memw(32'h18));
      drive(0, 0, 0, 0); expect_fetch(32'h1C, memw(32'h1C));

      // T4: redirect at PC=20, target low bits dropped
      drive(0, 1, 32'h0000_0103, 0);
      @(negedge CLK);
      chk("br_valid", {31'd0, VALID}, 32'd0);
      chk("br_addr", imem.IMEM_ADDRESS, 32'h20);
      drive(0, 0, 0, 0); expect_fetch(32'h100, memw(32'h100));
      @(negedge CLK);
      chk("br_new_addr", imem.IMEM_ADDRESS, 32'h100);
      drive(0, 1, 32'h30, 0);

      // T5: redirect while access at PC=30 is in flight, then a second redirect
      drive(0, 1, 32'h40, 1);
      @(negedge CLK);
      chk("disc_valid0", {31'd0, VALID}, 32'd0);
      drive(0, 1, 32'h80, 1);
      @(negedge CLK);
      chk("disc_addr", imem.IMEM_ADDRESS, 32'h30);
      chk("disc_read", {31'd0, imem.IMEM_READ}, 32'd1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      @(negedge CLK);
      chk("disc_valid_ret", {31'd0, VALID}, 32'd0);
      drive(0, 0, 0, 0); expect_fetch(32'h80, memw(32'h80));
      @(negedge CLK);
      chk("disc_new_addr", imem.IMEM_ADDRESS, 32'h80);
      drive(0, 1, 32'h50, 0);

      // T6: async reset while holding at PC=50
      drive(1, 0, 0, 0); expect_fetch(32'h50, memw(32'h50));
      drive(1, 0, 0, 0); expect_fetch(32'h50, memw(32'h50));
      @(negedge CLK);
      chk("hold_read", {31'd0, imem.IMEM_READ}, 32'd0);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_valid", {31'd0, VALID}, 32'd0);
      chk("arst_instr", INSTRUCTION, 32'h0000_0013);
      chk("arst_pc", PC, 32'h0);
      chk("arst_pc_plus_4", PC_PLUS_4, 32'h4);
      chk("arst_read", {31'd0, imem.IMEM_READ}, 32'd0);
      chk("arst_addr", imem.IMEM_ADDRESS, 32'h0);
      @(posedge CLK); #1;
      RESET_N = 1'b1; STALL = 1'b0;
      expect_fetch(32'h0, memw(32'h0));
      drive(0, 0, 0, 0); expect_fetch(32'h4, memw(32'h4));

      // PC wrap at top of address space
      drive(0, 1, 32'hFFFF_FFFF, 0);
      drive(0, 0, 0, 0); expect_fetch(32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
      @(negedge CLK);
      chk("wrap_pc_plus_4", PC_PLUS_4, 32'h0);
      drive(0, 0, 0, 0); expect_fetch(32'h0, memw(32'h0));
      @(negedge CLK); #1;
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
